// File: rtl/tpu_ctrl_pkg.sv
// Shared control-path types and constants for the instruction fetch path.
package tpu_ctrl_pkg;

    localparam int ICACHE_DEPTH    = 1024;
    localparam int ICACHE_ADDR_W   = 10;
    localparam int INS_LEN_DEFAULT = 54;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} fetch_state_t;

    typedef struct packed {
        logic [ICACHE_ADDR_W-1:0]   pc;
        logic [INS_LEN_DEFAULT-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_ctrl_fetch_fifo.sv
// Synchronous prefetch FIFO with push/pop/flush; full and empty derive from a
// registered occupancy count, so a same-cycle pop never frees a slot for a push.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; empty gates everything downstream that reads it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Walks a pc through the instruction store, prefetches into fetch_fifo and hands
// words to the decoder. Define INSTR_FETCH_PERF_EN to add stall/starve counters.
module instruction_fetch_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int INS_LEN    = INS_LEN_DEFAULT,
    parameter int ADDR_W     = ICACHE_ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    input  logic [ADDR_W:0]    ins_count,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               icache_rd_ctrl_en,
    output logic [ADDR_W-1:0]  icache_rd_ctrl_addr,
    input  logic [INS_LEN-1:0] icache_rd_ctrl_data,
    output logic               ins_valid,
    output logic [INS_LEN-1:0] ins_data,
    output logic [ADDR_W-1:0]  ins_pc,
    input  logic               ins_ready
`ifdef INSTR_FETCH_PERF_EN
   ,output logic [31:0]        perf_stall_cycles
   ,output logic [31:0]        perf_starve_cycles
`endif
);

    localparam int CW = ADDR_W + 1;
    localparam int EW = ADDR_W + INS_LEN;

    fetch_state_t    state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [CW-1:0]     fetch_left_q, fetch_left_d;
    logic [CW-1:0]     issue_left_q, issue_left_d;
    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [EW-1:0]     fifo_head;

    fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({pc_q, icache_rd_ctrl_data}),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    assign ins_valid = !fifo_empty;
    assign ins_data  = fifo_empty ? '0 : fifo_head[INS_LEN-1:0];
    assign ins_pc    = fifo_empty ? '0 : fifo_head[EW-1 -: ADDR_W];
    assign fifo_pop  = ins_valid && ins_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        fetch_left_d = fetch_left_q;
        issue_left_d = issue_left_q;
        fifo_push    = 1'b0;
        fifo_flush   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        if (fifo_pop && issue_left_q != '0) issue_left_d = issue_left_q - CW'(1);

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    busy         = 1'b1;
                    pc_d         = start_pc;
                    fetch_left_d = ins_count;
                    issue_left_d = ins_count;
                    state_d      = (ins_count == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (fetch_left_q != '0 && !fifo_full) begin
                    fifo_push    = 1'b1;
                    addr_d       = pc_q;
                    pc_d         = pc_q + ADDR_W'(1);
                    fetch_left_d = fetch_left_q - CW'(1);
                    if (fetch_left_q == CW'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (issue_left_q == '0) state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort cancels any in-flight read and drops buffered words without a done pulse.
        if (abort && state_q != IDLE) begin
            state_d      = IDLE;
            fifo_flush   = 1'b1;
            fifo_push    = 1'b0;
            done         = 1'b0;
            pc_d         = pc_q;
            addr_d       = addr_q;
            fetch_left_d = fetch_left_q;
        end

        icache_rd_ctrl_en   = fifo_push;
        icache_rd_ctrl_addr = fifo_push ? pc_q : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            addr_q       <= '0;
            fetch_left_q <= '0;
            issue_left_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            fetch_left_q <= fetch_left_d;
            issue_left_q <= issue_left_d;
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_starve_q, perf_starve_d;
    logic        start_accept;

    assign start_accept       = (state_q == IDLE) && start && !abort;
    assign perf_stall_cycles  = perf_stall_q;
    assign perf_starve_cycles = perf_starve_q;

    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_starve_d = perf_starve_q;
        if (start_accept) begin
            perf_stall_d  = '0;
            perf_starve_d = '0;
        end else begin
            if (busy && ins_valid && !ins_ready && perf_stall_q != '1)
                perf_stall_d = perf_stall_q + 32'd1;
            if (busy && !ins_valid && issue_left_q != '0 && perf_starve_q != '1)
                perf_starve_d = perf_starve_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_starve_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_starve_q <= perf_starve_d;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Directed bench for instruction_fetch_ctrl: basic run, backpressure, pc wrap,
// zero count, abort, mid-run reset and start-while-busy.
module tb_instruction_fetch_ctrl;
    import tpu_ctrl_pkg::*;

    localparam int INS_LEN = 54;
    localparam int ADDR_W  = 10;

    logic               clk = 1'b0;
    logic               rst, start, abort, ins_ready;
    logic [ADDR_W-1:0]  start_pc;
    logic [ADDR_W:0]    ins_count;
    logic               busy, done, icache_rd_ctrl_en, ins_valid;
    logic [ADDR_W-1:0]  icache_rd_ctrl_addr, ins_pc;
    logic [INS_LEN-1:0] icache_rd_ctrl_data, ins_data;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0]        perf_stall_cycles, perf_starve_cycles;
`endif

    logic [INS_LEN-1:0] imem [ICACHE_DEPTH];
    assign icache_rd_ctrl_data = imem[icache_rd_ctrl_addr];

    instruction_fetch_ctrl #(.INS_LEN(INS_LEN), .ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .start_pc            (start_pc),
        .ins_count           (ins_count),
        .abort               (abort),
        .busy                (busy),
        .done                (done),
        .icache_rd_ctrl_en   (icache_rd_ctrl_en),
        .icache_rd_ctrl_addr (icache_rd_ctrl_addr),
        .icache_rd_ctrl_data (icache_rd_ctrl_data),
        .ins_valid           (ins_valid),
        .ins_data            (ins_data),
        .ins_pc              (ins_pc),
        .ins_ready           (ins_ready)
`ifdef INSTR_FETCH_PERF_EN
       ,.perf_stall_cycles   (perf_stall_cycles)
       ,.perf_starve_cycles  (perf_starve_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned        reads[$];
    logic [ADDR_W-1:0]  pop_pc[$];
    logic [INS_LEN-1:0] pop_data[$];
    int                 pop_cyc[$];
    int                 done_cnt, done_cyc, stab_err, reads_before_pop, start_cyc;
    logic               hold = 1'b0;
    logic [INS_LEN-1:0] hold_data;
    logic [ADDR_W-1:0]  hold_pc;
    int                 n_cmp = 0;
    int                 n_bad = 0;

    // Monitor on the falling edge: values here are what the next rising edge consumes.
    always @(negedge clk) begin
        if (icache_rd_ctrl_en) begin
            reads.push_back(int'(icache_rd_ctrl_addr));
            if (pop_pc.size() == 0) reads_before_pop++;
        end
        if (ins_valid && ins_ready) begin
            pop_pc.push_back(ins_pc);
            pop_data.push_back(ins_data);
            pop_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (hold && (ins_data !== hold_data || ins_pc !== hold_pc)) stab_err++;
        hold      = ins_valid && !ins_ready;
        hold_data = ins_data;
        hold_pc   = ins_pc;
    end

    function automatic logic [INS_LEN-1:0] word_at(input int a);
        logic [ADDR_W-1:0] a10;
        a10 = ADDR_W'(a);
        if (a >= 10 && a <= 13) return INS_LEN'(8'hA0 + (a - 10));
        return {20'hC0DE5, 24'h0, a10};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        reads.delete();
        pop_pc.delete();
        pop_data.delete();
        pop_cyc.delete();
        done_cnt         = 0;
        stab_err         = 0;
        reads_before_pop = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; start is accepted at the following rising edge.
    task automatic launch(input logic [ADDR_W-1:0] pc, input logic [ADDR_W:0] n);
        start     = 1'b1;
        start_pc  = pc;
        ins_count = n;
        start_cyc = cyc;
        @(negedge clk);
        check("busy_at_accept", 64'(busy), 64'd1);
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit bp);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            if (bp) ins_ready = pat[k % 4];
            step(1);
            k++;
        end
        ins_ready = 1'b1;
    endtask

    task automatic check_stream(input string tag, input int base, input int n);
        check({tag, "_pop_count"}, 64'(pop_data.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            int a = (base + i) % ICACHE_DEPTH;
            check({tag, "_data"}, (i < pop_data.size()) ? 64'(pop_data[i]) : 'x, 64'(word_at(a)));
            check({tag, "_pc"}, (i < pop_pc.size()) ? 64'(pop_pc[i]) : 'x, 64'(a));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_en"}, 64'(icache_rd_ctrl_en), 64'd0);
        check({tag, "_addr"}, 64'(icache_rd_ctrl_addr), 64'd0);
        check({tag, "_valid"}, 64'(ins_valid), 64'd0);
        check({tag, "_data"}, 64'(ins_data), 64'd0);
        check({tag, "_pc"}, 64'(ins_pc), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < ICACHE_DEPTH; a++) imem[a] = word_at(a);
        rst = 1'b1; start = 1'b0; abort = 1'b0; ins_ready = 1'b0;
        start_pc = '0; ins_count = '0;
        clear_logs();
        step(3);

        // Reset values
        @(negedge clk);
        check_outputs_zero("reset");
        step(1);
        rst = 1'b0;
        step(1);

        // Basic run: 4 words back to back, one done pulse
        clear_logs();
        ins_ready = 1'b1;
        launch(10'd10, 11'd4);
        wait_done(40, 1'b0);
        check("basic_done_count", 64'(done_cnt), 64'd1);
        check_stream("basic", 10, 4);
        check("basic_consecutive", (pop_cyc.size() == 4) ? 64'(pop_cyc[3] - pop_cyc[0]) : 'x, 64'd3);
        check("basic_reads", 64'(reads.size()), 64'd4);
        @(negedge clk);
        check("basic_busy_after", 64'(busy), 64'd0);
        check("basic_done_after", 64'(done), 64'd0);
        step(1);

        // Backpressure: ready pattern 1,0,0,1
        clear_logs();
        launch(10'd10, 11'd4);
        wait_done(60, 1'b1);
        check("bp_done_count", 64'(done_cnt), 64'd1);
        check_stream("bp", 10, 4);
        check("bp_stable", 64'(stab_err), 64'd0);
        check("bp_reads_before_pop", 64'(reads_before_pop), 64'd2);
        check("bp_reads", 64'(reads.size()), 64'd4);
        step(2);

        // Wrap-around: 1022, 1023, 0, 1
        clear_logs();
        launch(10'd1022, 11'd4);
        wait_done(40, 1'b0);
        check("wrap_done_count", 64'(done_cnt), 64'd1);
        check_stream("wrap", 1022, 4);
        for (int i = 0; i < 4; i++)
            check("wrap_read_addr", (i < reads.size()) ? 64'(reads[i]) : 'x, 64'((1022 + i) % 1024));
        step(2);

        // Zero count: no reads, done within 2 cycles
        clear_logs();
        launch(10'd7, 11'd0);
        wait_done(10, 1'b0);
        check("zero_done_count", 64'(done_cnt), 64'd1);
        check("zero_reads", 64'(reads.size()), 64'd0);
        check("zero_latency_le2", 64'((done_cyc - start_cyc) <= 2), 64'd1);
        step(2);

        // Abort two cycles into a long run with the decoder stalled
        clear_logs();
        ins_ready = 1'b0;
        launch(10'd100, 11'd100);
        step(1);
        abort = 1'b1;
        @(negedge clk);
        check("abort_valid_before", 64'(ins_valid), 64'd1);
        step(1);
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid_after", 64'(ins_valid), 64'd0);
        check("abort_busy_after", 64'(busy), 64'd0);
        check("abort_en_after", 64'(icache_rd_ctrl_en), 64'd0);
        step(5);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        clear_logs();
        ins_ready = 1'b1;
        launch(10'd10, 11'd4);
        wait_done(40, 1'b0);
        check("post_abort_done", 64'(done_cnt), 64'd1);
        check_stream("post_abort", 10, 4);
        step(2);

        // Reset asserted mid-run
        clear_logs();
        ins_ready = 1'b0;
        launch(10'd200, 11'd50);
        step(2);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        check_outputs_zero("midrst");
        step(1);
        rst = 1'b0;
        step(3);
        check("midrst_no_done", 64'(done_cnt), 64'd0);

        // A start pulse during FETCH is ignored
        clear_logs();
        ins_ready = 1'b1;
        launch(10'd10, 11'd4);
        start     = 1'b1;
        start_pc  = 10'd500;
        ins_count = 11'd7;
        step(1);
        start = 1'b0;
        wait_done(40, 1'b0);
        step(4);
        check("busy_start_done_count", 64'(done_cnt), 64'd1);
        check_stream("busy_start", 10, 4);
        check("busy_start_reads", 64'(reads.size()), 64'd4);
        check("busy_start_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
